// File: rtl/nanorv32_prefetch_pkg.sv
// nanorv32 prefetch shared definitions: fetch FSM encoding and instruction size.
package nanorv32_prefetch_pkg;

   typedef enum logic [1:0] {
      PF_IDLE = 2'd0,
      PF_REQ  = 2'd1,
      PF_DROP = 2'd2
   } pf_state_e;

   localparam int unsigned NRV32_INSTR_BYTES = 4;

endpackage

// File: rtl/nanorv32_prefetch_fifo_sync.sv
// Synchronous flop FIFO with flush; push and pop may coincide at any fill level.
module nanorv32_fifo_sync #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop & (count_q != '0);
   // Writing while full is allowed only when the same cycle frees the head slot.
   assign do_push = push & ((count_q != CW'(DEPTH)) | do_pop);

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // State registers; storage clears on reset so the head reads zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/nanorv32_prefetch.sv
// nanorv32 instruction prefetch: sequential word fetch into a small buffer,
// branch redirect with flush and discard of any in-flight response.
module nanorv32_prefetch
   import nanorv32_prefetch_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        DATA_W   = 32,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] cpu_codemem_addr,
   output logic              cpu_codemem_valid,
   input  logic [DATA_W-1:0] codemem_cpu_rdata,
   input  logic              codemem_cpu_ready,
   input  logic              branch_req,
   input  logic [ADDR_W-1:0] branch_addr,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned FW = DATA_W + ADDR_W;

   pf_state_e         state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] pending_pc_q, pending_pc_d;

   logic              fifo_flush;
   logic              fifo_push;
   logic              fifo_pop;
   logic [FW-1:0]     fifo_wdata;
   logic [FW-1:0]     fifo_rdata;
   logic [CW-1:0]     fifo_count;
   logic              fifo_empty;
   logic              fifo_full;

   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] seq_pc;
   logic [CW-1:0]     count_after;

   assign branch_target = branch_addr & ~ADDR_W'(3);
   assign seq_pc        = fetch_pc_q + ADDR_W'(NRV32_INSTR_BYTES);
   // A redirect flushes the buffer, so a same-cycle pop is meaningless.
   assign fifo_pop      = ~fifo_empty & instr_ready & ~branch_req;
   assign fifo_flush    = branch_req;
   assign fifo_wdata    = {fetch_pc_q, codemem_cpu_rdata};
   // Only evaluated in REQ where count < DEPTH, so count+1 cannot overflow CW bits.
   assign count_after   = fifo_count + CW'(1) - CW'(fifo_pop);

   // Fetch FSM next-state, fetch/pending PC update and push decision.
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      pending_pc_d = pending_pc_q;
      fifo_push    = 1'b0;
      case (state_q)
         PF_IDLE: begin
            if (branch_req) begin
               fetch_pc_d = branch_target;
               state_d    = PF_REQ;
            end else if (!fifo_full) begin
               state_d = PF_REQ;
            end
         end
         PF_REQ: begin
            if (branch_req) begin
               if (codemem_cpu_ready) begin
                  fetch_pc_d = branch_target;
               end else begin
                  pending_pc_d = branch_target;
                  state_d      = PF_DROP;
               end
            end else if (codemem_cpu_ready) begin
               fifo_push  = 1'b1;
               fetch_pc_d = seq_pc;
               if (count_after >= CW'(DEPTH)) begin
                  state_d = PF_IDLE;
               end
            end
         end
         PF_DROP: begin
            // Address stays on the abandoned request until memory completes it.
            if (branch_req) begin
               pending_pc_d = branch_target;
               if (codemem_cpu_ready) begin
                  fetch_pc_d = branch_target;
                  state_d    = PF_REQ;
               end
            end else if (codemem_cpu_ready) begin
               fetch_pc_d = pending_pc_q;
               state_d    = PF_REQ;
            end
         end
         default: begin
            state_d = PF_IDLE;
         end
      endcase
   end

   // Fetch FSM and PC registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= PF_IDLE;
         fetch_pc_q   <= RESET_PC;
         pending_pc_q <= RESET_PC;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         pending_pc_q <= pending_pc_d;
      end
   end

   nanorv32_fifo_sync #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (fifo_flush),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign cpu_codemem_valid        = (state_q != PF_IDLE);
   assign cpu_codemem_addr         = fetch_pc_q;
   assign instr_valid              = ~fifo_empty;
   assign {instr_pc, instr_data}   = fifo_rdata;

endmodule

// File: tb/tb_nanorv32_prefetch.sv
// Self-checking bench for nanorv32_prefetch: directed scenarios plus random
// traffic against a transaction-level model (instruction queue + outstanding request).
module tb_nanorv32_prefetch;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        br_req = 1'b0;
   logic [31:0] br_addr = '0;
   logic        iv;
   logic [31:0] idata;
   logic [31:0] ipc;
   logic        iready = 1'b0;

   logic [31:0] w_addr;
   logic        w_valid;
   logic        w_iv;
   logic [31:0] w_idata;
   logic [31:0] w_ipc;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

   entry_t      q[$];
   bit          m_busy;
   bit          m_discard;
   logic [31:0] m_addr;
   logic [31:0] m_next;

   always #5 clk = ~clk;

   nanorv32_prefetch #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .cpu_codemem_addr  (mem_addr),
      .cpu_codemem_valid (mem_valid),
      .codemem_cpu_rdata (mem_rdata),
      .codemem_cpu_ready (mem_ready),
      .branch_req        (br_req),
      .branch_addr       (br_addr),
      .instr_valid       (iv),
      .instr_data        (idata),
      .instr_pc          (ipc),
      .instr_ready       (iready)
   );

   nanorv32_prefetch #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .DEPTH    (DEPTH),
      .RESET_PC (32'hFFFF_FFF8)
   ) u_wrap (
      .clk               (clk),
      .rst               (rst),
      .cpu_codemem_addr  (w_addr),
      .cpu_codemem_valid (w_valid),
      .codemem_cpu_rdata (32'hDEAD_BEEF),
      .codemem_cpu_ready (1'b1),
      .branch_req        (1'b0),
      .branch_addr       (32'h0),
      .instr_valid       (w_iv),
      .instr_data        (w_idata),
      .instr_pc          (w_ipc),
      .instr_ready       (1'b1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_busy    = 1'b0;
      m_discard = 1'b0;
      m_addr    = 32'h0;
      m_next    = 32'h0;
   endtask

   // One clock edge of the reference behaviour, using the inputs held across it.
   task automatic model_step(input logic rdy, input logic [31:0] rd, input logic br,
                             input logic [31:0] ba, input logic ir);
      logic [31:0] tgt;
      bit          fire;
      bit          popped;
      int          occ_before;
      tgt        = ba & 32'hFFFF_FFFC;
      fire       = m_busy && rdy;
      popped     = (q.size() != 0) && ir && !br;
      occ_before = q.size();
      if (br) begin
         q.delete();
         if (fire || !m_busy) begin
            m_busy    = 1'b1;
            m_discard = 1'b0;
            m_addr    = tgt;
            m_next    = tgt;
         end else begin
            m_discard = 1'b1;
            m_next    = tgt;
         end
      end else begin
         if (popped) void'(q.pop_front());
         if (fire) begin
            if (m_discard) begin
               m_discard = 1'b0;
               m_addr    = m_next;
            end else begin
               q.push_back('{pc: m_addr, data: rd});
               m_next = m_addr + 32'd4;
               if (q.size() < DEPTH) m_addr = m_next;
               else m_busy = 1'b0;
            end
         end else if (!m_busy && occ_before < DEPTH) begin
            m_busy = 1'b1;
            m_addr = m_next;
         end
      end
   endtask

   task automatic model_check();
      chk("mem_valid", 32'(mem_valid), 32'(m_busy));
      if (m_busy) chk("mem_addr", mem_addr, m_addr);
      chk("instr_valid", 32'(iv), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("instr_pc", ipc, q[0].pc);
         chk("instr_data", idata, q[0].data);
      end
   endtask

   // Starts and ends on a falling edge: drive, clock, then compare.
   task automatic cycle(input logic rdy, input logic [31:0] rd, input logic br,
                        input logic [31:0] ba, input logic ir);
      mem_ready = rdy;
      mem_rdata = rd;
      br_req    = br;
      br_addr   = ba;
      iready    = ir;
      @(posedge clk);
      model_step(rdy, rd, br, ba, ir);
      @(negedge clk);
      model_check();
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      mem_ready = 1'b0;
      br_req    = 1'b0;
      iready    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(mem_valid), 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_ivalid", 32'(iv), 32'h0);
      chk("rst_idata", idata, 32'h0);
      chk("rst_ipc", ipc, 32'h0);
      chk("rst_wrap_valid", 32'(w_valid), 32'h0);
      chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
      model_reset();
      rst = 1'b0;
   endtask

   initial begin
      int unsigned ir_pct;
      logic        r_rdy, r_br, r_ir;
      logic [31:0] r_ba;

      @(negedge clk);

      // Streaming start-up with zero-wait memory and consumer; wrap instance alongside.
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b1);
         chk("stream_valid", 32'(mem_valid), 32'h1);
         chk("stream_addr", mem_addr, 32'(4 * (k - 1)));
         chk("stream_ivalid", 32'(iv), 32'(k >= 2));
         if (k >= 2) chk("stream_ipc", ipc, 32'(4 * (k - 2)));
         if (k == 1) chk("wrap_addr0", w_addr, 32'hFFFF_FFF8);
         if (k == 2) chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
         if (k == 3) begin
            chk("wrap_addr2", w_addr, 32'h0000_0000);
            chk("wrap_ipc", w_ipc, 32'hFFFF_FFFC);
            chk("wrap_idata", w_idata, 32'hDEAD_BEEF);
         end
      end

      // Stalled consumer: four words fill the buffer, fetch stops, one pop re-arms it.
      do_reset();
      for (int k = 0; k < 5; k++) cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
      chk("full_valid_low", 32'(mem_valid), 32'h0);
      cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
      chk("full_still_idle", 32'(mem_valid), 32'h0);
      chk("full_head_pc", ipc, 32'h0);
      cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b1);
      chk("full_bubble", 32'(mem_valid), 32'h0);
      chk("full_next_head", ipc, 32'h4);
      cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
      chk("full_rearm_valid", 32'(mem_valid), 32'h1);
      chk("full_rearm_addr", mem_addr, 32'h10);

      // Slow memory, redirect during the first wait cycle.
      do_reset();
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1, 32'h0000_0103, 1'b1);
      chk("drop_addr_held", mem_addr, 32'h0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("drop_valid_held", 32'(mem_valid), 32'h1);
      cycle(1'b1, 32'hBAD0_BAD0, 1'b0, 32'h0, 1'b1);
      chk("drop_redirect_addr", mem_addr, 32'h100);
      chk("drop_no_word", 32'(iv), 32'h0);
      cycle(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
      chk("drop_target_pc", ipc, 32'h100);
      chk("drop_target_data", idata, 32'h1234_5678);

      // Redirect together with ready and pop.
      do_reset();
      cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, $urandom, 1'b1, 32'h40, 1'b1);
      chk("brpop_empty", 32'(iv), 32'h0);
      chk("brpop_addr", mem_addr, 32'h40);
      cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
      chk("brpop_head", ipc, 32'h40);

      // Two redirects while the old request is still outstanding.
      do_reset();
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
      cycle(1'b0, 32'h0, 1'b1, 32'h300, 1'b1);
      chk("dbl_addr_held", mem_addr, 32'h0);
      cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b1);
      chk("dbl_addr", mem_addr, 32'h300);
      cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
      chk("dbl_head", ipc, 32'h300);

      // Asynchronous reset while a request is pending.
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(mem_valid), 32'h0);
      chk("arst_addr", mem_addr, 32'h0);
      chk("arst_ivalid", 32'(iv), 32'h0);
      do_reset();
      cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b1);
      chk("arst_restart", mem_addr, 32'h0);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         ir_pct = (n / 500) % 2 == 0 ? 30 : 85;
         r_rdy  = ($urandom_range(0, 99) < 60);
         r_ir   = ($urandom_range(0, 99) < ir_pct);
         r_br   = ($urandom_range(0, 15) == 0);
         r_ba   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
         cycle(r_rdy, $urandom, r_br, r_ba, r_ir);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
